// File: rtl/mbc_control_unit.sv
// Hardwired timing-and-control unit for the basic computer: sequence counter, run/halt state
// and IR decode into register strobes, bus select, ALU function and memory strobes.
module mbc_control_unit (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        ac_sign,
  input  logic        ac_zero,
  input  logic        dr_zero,
  input  logic        e_flag,
  output logic        ar_ld,
  output logic        ar_inc,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        dr_ld,
  output logic        dr_inc,
  output logic        ac_ld,
  output logic        ac_inc,
  output logic        ac_clr,
  output logic        ir_ld,
  output logic        tr_ld,
  output logic        e_clr,
  output logic        e_cmp,
  output logic        e_ld,
  output logic [2:0]  bus_sel,
  output logic [2:0]  alu_op,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        running,
  output logic        halted
);

  localparam logic [2:0] BusNone = 3'd0;
  localparam logic [2:0] BusAr   = 3'd1;
  localparam logic [2:0] BusPc   = 3'd2;
  localparam logic [2:0] BusDr   = 3'd3;
  localparam logic [2:0] BusAc   = 3'd4;
  localparam logic [2:0] BusIr   = 3'd5;
  localparam logic [2:0] BusMem  = 3'd7;

  localparam logic [2:0] AluAnd  = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd1;
  localparam logic [2:0] AluCma  = 3'd3;
  localparam logic [2:0] AluShr  = 3'd4;
  localparam logic [2:0] AluShl  = 3'd5;

  localparam logic [2:0] OpAnd = 3'd0;
  localparam logic [2:0] OpAdd = 3'd1;
  localparam logic [2:0] OpLda = 3'd2;
  localparam logic [2:0] OpSta = 3'd3;
  localparam logic [2:0] OpBun = 3'd4;
  localparam logic [2:0] OpBsa = 3'd5;
  localparam logic [2:0] OpIsz = 3'd6;
  localparam logic [2:0] OpReg = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e     state_q;
  logic [2:0] sc_q;
  logic       i_q;
  logic [2:0] d_q;

  logic       sc_clr;
  logic       halt_req;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= StIdle;
      sc_q    <= 3'd0;
      i_q     <= 1'b0;
      d_q     <= 3'd0;
    end else begin
      case (state_q)
        StIdle, StHalt: begin
          if (start) begin
            state_q <= StRun;
            sc_q    <= 3'd0;
          end
        end
        StRun: begin
          sc_q <= sc_clr ? 3'd0 : sc_q + 3'd1;
          if (sc_q == 3'd2) begin
            i_q <= ir[15];
            d_q <= ir[14:12];
          end
          if (halt_req) state_q <= StHalt;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign running = (state_q == StRun);
  assign halted  = (state_q == StHalt);

  always_comb begin
    ar_ld    = 1'b0;
    ar_inc   = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    dr_ld    = 1'b0;
    dr_inc   = 1'b0;
    ac_ld    = 1'b0;
    ac_inc   = 1'b0;
    ac_clr   = 1'b0;
    ir_ld    = 1'b0;
    tr_ld    = 1'b0;
    e_clr    = 1'b0;
    e_cmp    = 1'b0;
    e_ld     = 1'b0;
    bus_sel  = BusNone;
    alu_op   = AluAnd;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    sc_clr   = 1'b0;
    halt_req = 1'b0;

    if (state_q == StRun) begin
      case (sc_q)
        3'd0: begin
          bus_sel = BusPc;
          ar_ld   = 1'b1;
        end
        3'd1: begin
          mem_rd  = 1'b1;
          bus_sel = BusMem;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        3'd2: begin
          bus_sel = BusIr;
          ar_ld   = 1'b1;
        end
        3'd3: begin
          if (d_q == OpReg) begin
            sc_clr = 1'b1;
            // Register-reference reads the live ir bits; I/O (I=1) is a NOP.
            if (!i_q) begin
              if (ir[11]) begin
                ac_clr = 1'b1;
              end else if (ir[9]) begin
                ac_ld  = 1'b1;
                alu_op = AluCma;
              end else if (ir[7]) begin
                ac_ld  = 1'b1;
                alu_op = AluShr;
                e_ld   = 1'b1;
              end else if (ir[6]) begin
                ac_ld  = 1'b1;
                alu_op = AluShl;
                e_ld   = 1'b1;
              end else if (ir[5]) begin
                ac_inc = 1'b1;
              end
              if (ir[10]) begin
                e_clr = 1'b1;
              end else if (ir[8]) begin
                e_cmp = 1'b1;
              end
              pc_inc   = (ir[4] && !ac_sign) || (ir[3] && ac_sign) ||
                         (ir[2] && ac_zero)  || (ir[1] && !e_flag);
              halt_req = ir[0];
            end
          end else if (i_q) begin
            mem_rd  = 1'b1;
            bus_sel = BusMem;
            ar_ld   = 1'b1;
          end
        end
        3'd4: begin
          case (d_q)
            OpAnd, OpAdd, OpLda, OpIsz: begin
              mem_rd  = 1'b1;
              bus_sel = BusMem;
              dr_ld   = 1'b1;
            end
            OpSta: begin
              bus_sel = BusAc;
              mem_wr  = 1'b1;
              sc_clr  = 1'b1;
            end
            OpBun: begin
              bus_sel = BusAr;
              pc_ld   = 1'b1;
              sc_clr  = 1'b1;
            end
            OpBsa: begin
              bus_sel = BusPc;
              mem_wr  = 1'b1;
              ar_inc  = 1'b1;
            end
            default: sc_clr = 1'b1;
          endcase
        end
        3'd5: begin
          case (d_q)
            OpAnd, OpAdd, OpLda: begin
              ac_ld  = 1'b1;
              alu_op = d_q;
              e_ld   = (d_q == OpAdd);
              sc_clr = 1'b1;
            end
            OpBsa: begin
              bus_sel = BusAr;
              pc_ld   = 1'b1;
              sc_clr  = 1'b1;
            end
            OpIsz:   dr_inc = 1'b1;
            default: sc_clr = 1'b1;
          endcase
        end
        3'd6: begin
          sc_clr = 1'b1;
          if (d_q == OpIsz) begin
            bus_sel = BusDr;
            mem_wr  = 1'b1;
            pc_inc  = dr_zero;
          end
        end
        default: sc_clr = 1'b1;
      endcase
    end
  end

endmodule

// File: doc/mbc_control_unit.md
# mbc_control_unit

Hardwired timing-and-control unit for the basic computer. It owns the sequence counter and the run/halt state, and decodes IR. It drives the load, increment and clear strobes of the AR, PC, DR, AC, IR and TR registers, the common-bus select, the ALU operation and the memory strobes, executing one fetch–decode–execute instruction cycle at a time.

## Interface
- No parameters. Word width is fixed at 16 bits and address width at 12 bits.
- clock  in  1  system clock; all state advances on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE or HALT; ignored in RUN.
- ir  in  16  IR contents. Bit 15 is I, bits 14:12 are the opcode, bits 11:0 are the address or register-reference bits.
- ac_sign, ac_zero, dr_zero, e_flag  in  1 each  status from the AC, DR and E registers.
- ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ac_inc, ac_clr, ir_ld, tr_ld  out  1 each  register strobes.
- e_clr, e_cmp, e_ld  out  1 each  E flip-flop controls. e_ld loads the ALU carry or shift-out bit.
- bus_sel  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory.
- alu_op  out  3  ALU function: 0 AND, 1 ADD, 2 pass DR, 3 complement AC, 4 shift right through E, 5 shift left through E.
- mem_rd, mem_wr  out  1 each  memory strobes. Address is AR. Read data goes onto the bus in the same cycle.
- running, halted  out  1 each  state indication.

## Operation
- Top state has three values: IDLE, RUN and HALT.
  - IDLE to RUN: on start.
  - RUN to HALT: on HLT.
  - HALT to RUN: on start.
- In IDLE and HALT, every strobe and select output is 0.
- Sequence counter SC is 3 bits, counting T0 to T6. It increments each RUN cycle and returns to 0 in the final cycle of every instruction.
- At T2 the unit latches I = ir[15] and D = ir[14:12]. Decode uses only these latched values from T3 onward.

Fetch and decode, all instructions:
- T0: bus_sel=PC, ar_ld.
- T1: mem_rd, bus_sel=7, ir_ld, pc_inc.
- T2: bus_sel=IR, ar_ld. AR takes the bus low 12 bits.
- T3, memory-reference (D≠7):
  - If I=1: mem_rd, bus_sel=7, ar_ld.
  - If I=0: no strobes.
- T3, D=7 and I=0 (register-reference): execute, SC←0.
  - AC actions, at most one per cycle, priority CLA(b11) > CMA(b9) > CIR(b7) > CIL(b6) > INC(b5).
  - E actions, priority CLE(b10) > CME(b8). CIR and CIL assert e_ld.
  - Skips: SPA(b4) when ac_sign=0, SNA(b3) when ac_sign=1, SZA(b2) when ac_zero=1, SZE(b1) when e_flag=0. The satisfied skip conditions are ORed into a single pc_inc.
  - HLT(b0) enters HALT at the end of T3. Other bits set in the same word still execute.
- T3, D=7 and I=1 (I/O): treated as NOP, SC←0.

Memory-reference execute, T4 onward:
- AND, ADD, LDA:
  - T4: mem_rd, bus_sel=7, dr_ld.
  - T5: ac_ld with alu_op 0, 1 or 2 respectively. ADD also asserts e_ld. SC←0.
- STA, T4: bus_sel=AC, mem_wr, SC←0.
- BUN, T4: bus_sel=AR, pc_ld, SC←0.
- BSA:
  - T4: bus_sel=PC, mem_wr, ar_inc.
  - T5: bus_sel=AR, pc_ld, SC←0.
- ISZ:
  - T4: mem_rd, bus_sel=7, dr_ld.
  - T5: dr_inc.
  - T6: bus_sel=DR, mem_wr, pc_inc if dr_zero, SC←0. dr_zero reflects the incremented DR.

Rules that hold in every cycle:
- Exactly one bus source per cycle.
- Never inc and ld on the same register in the same cycle.
- Never mem_rd and mem_wr together.

## Timing
- All outputs are a combinational decode of registered state: top state, SC, latched I/D, and ir during T3 register-reference.
- Outputs are glitch-free relative to clock. They are valid from shortly after the rising edge and take effect at the next rising edge.
- Instruction length in cycles, counting T0 through the last state:
  - Register-reference, I/O and HLT: 4.
  - STA and BUN: 5.
  - AND, ADD, LDA and BSA: 6.
  - ISZ: 7.
  - Indirect addressing adds no cycles.
- start seen in IDLE or HALT: the first T0 is the next cycle. A start pulse during RUN has no effect.
- Reset, including mid-instruction, acts immediately and asynchronously:
  - State goes to IDLE, SC to 0, latched I/D to 0.
  - Every output goes to 0 (running=0, halted=0).
  - No partial memory write is re-issued after release.

## Test plan
- Reset release, then hold start low for 10 cycles: all outputs stay 0 and running=0. Then pulse start: the next cycle shows bus_sel=2 and ar_ld=1.
- ir=0x2005 (LDA direct): exactly 6 RUN cycles. T4 has mem_rd, bus_sel=7, dr_ld. T5 has ac_ld, alu_op=2. The next cycle is T0.
- ir=0xE010 (ISZ indirect):
  - T3 asserts mem_rd and ar_ld.
  - T6 asserts mem_wr and bus_sel=3.
  - pc_inc at T6 only when dr_zero=1. Check with dr_zero=0 and with dr_zero=1.
- ir=0x7814 (CLA+SPA+SZA) with ac_sign=0 and ac_zero=1: single cycle T3 with ac_clr=1 and pc_inc=1 once, ac_ld=0, length 4 cycles.
- ir=0x7001 (HLT): halted=1 from the cycle after T3 and all strobes 0. start resumes at T0 with bus_sel=2.
- Assert clear_n low during T4 of BSA: mem_wr, ar_inc and all strobes drop to 0 within the same cycle. After release the unit sits in IDLE until start.
